// File: rtl/control_pkg.sv
// Shared definitions for the ARM-subset control path: ALU op codes, opcode
// classes, condition codes, run states and the condition-pass function.
package control_pkg;

  localparam int FLAG_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_ORR = 4'b0011
  } alu_op_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_t;

  typedef enum logic [1:0] {
    ST_START,
    ST_RUN,
    ST_HALT
  } run_state_t;

  // nzcv packs the flags as {N, Z, C, V}.
  function automatic logic cond_pass(input cond_t c, input logic [3:0] nzcv);
    logic n, z, cf, v;
    {n, z, cf, v} = nzcv;
    case (c)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return cf;
      COND_CC: return !cf;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return cf && !z;
      COND_LS: return !cf || z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z && (n == v);
      COND_LE: return z || (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cond_check.sv
// Flag register, run-state FSM and condition gating of the raw decode enables.
module cond_check
  import control_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cond,
  input  logic              undef,
  input  logic [3:0]        nzcv_in,
  input  logic              reg_write_raw,
  input  logic              mem_write_raw,
  input  logic              branch_raw,
  input  logic              flag_write_raw,
  input  logic              cv_write,
  input  logic              rd_is_pc,
  output logic              reg_write,
  output logic              mem_write,
  output logic              pc_src,
  output logic              halted
);

  run_state_t state;
  logic [3:0] nzcv;
  logic       cond_ex;

  // Reset gates immediately, so a reset mid-program kills this cycle's writes.
  assign cond_ex   = cond_pass(cond_t'(cond), nzcv) && (state == ST_RUN) && !rst;
  assign reg_write = reg_write_raw && cond_ex;
  assign mem_write = mem_write_raw && cond_ex;
  assign pc_src    = (branch_raw || (reg_write_raw && rd_is_pc)) && cond_ex;

  // NOTE: every register here is assigned with <= so all updates see the
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_START;
      halted <= 1'b0;
      nzcv   <= 4'b0000;
    end else begin
      case (state)
        ST_START: state <= ST_RUN;
        ST_RUN: begin
          if (undef) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end
        end
        default: state <= ST_HALT;
      endcase
      if (flag_write_raw && cond_ex) begin
        nzcv[3:2] <= nzcv_in[3:2];
        if (cv_write) nzcv[1:0] <= nzcv_in[1:0];
      end
    end
  end

endmodule

// File: rtl/control_unit.sv
// Control unit for the single-cycle ARM-subset datapath: main/ALU decode plus
// condition-gated strobes. Optional CMP/TST decode: define CONTROL_UNIT_CMP_EN.
module control_unit
  import control_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cond,
  input  logic [1:0]        op,
  input  logic [5:0]        funct,
  input  logic [3:0]        rd,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              pc_src,
  output logic              mem_to_reg,
  output logic              mem_write,
  output logic [3:0]        alu_control,
  output logic              alu_src,
  output logic              reg_write,
  output logic [1:0]        reg_src,
  output logic              halted
);

  alu_op_t alu_op, dp_alu;
  logic    dp_reg_write, dp_flag_force;
  logic    reg_write_raw, mem_write_raw, branch_raw, flag_write_raw, undef;
  logic    cv_write;
  logic    unused_flag_bit;

  assign unused_flag_bit = alu_flags[0];

  // NOTE: each always_comb assigns defaults first so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    dp_alu        = ALU_ADD;
    dp_reg_write  = 1'b0;
    dp_flag_force = 1'b0;
    case (funct[4:1])
      4'b0100: begin dp_alu = ALU_ADD; dp_reg_write = 1'b1; end
      4'b0010: begin dp_alu = ALU_SUB; dp_reg_write = 1'b1; end
      4'b0000: begin dp_alu = ALU_AND; dp_reg_write = 1'b1; end
      4'b1100: begin dp_alu = ALU_ORR; dp_reg_write = 1'b1; end
`ifdef CONTROL_UNIT_CMP_EN
      4'b1010: begin dp_alu = ALU_SUB; dp_flag_force = 1'b1; end
      4'b1000: begin dp_alu = ALU_AND; dp_flag_force = 1'b1; end
`endif
      default: begin dp_alu = ALU_ADD; dp_reg_write = 1'b0; end
    endcase
  end

  always_comb begin
    alu_op         = ALU_ADD;
    alu_src        = 1'b0;
    reg_src        = 2'b00;
    mem_to_reg     = 1'b0;
    reg_write_raw  = 1'b0;
    mem_write_raw  = 1'b0;
    branch_raw     = 1'b0;
    flag_write_raw = 1'b0;
    undef          = 1'b0;
    case (op)
      OP_DP: begin
        alu_op         = dp_alu;
        alu_src        = funct[5];
        reg_src        = {funct[5], 1'b0};
        reg_write_raw  = dp_reg_write;
        flag_write_raw = funct[0] | dp_flag_force;
      end
      OP_MEM: begin
        alu_src       = 1'b1;
        reg_src[1]    = 1'b1;
        mem_to_reg    = funct[0];
        reg_write_raw = funct[0];
        mem_write_raw = !funct[0];
      end
      OP_BR: begin
        alu_src    = 1'b1;
        reg_src    = 2'b01;
        branch_raw = 1'b1;
      end
      default: undef = 1'b1;
    endcase
  end

  assign alu_control = alu_op;
  // Logical ops leave carry and overflow untouched.
  assign cv_write    = (alu_op == ALU_ADD) || (alu_op == ALU_SUB);

  cond_check u_cond_check (
    .clk            (clk),
    .rst            (rst),
    .cond           (cond),
    .undef          (undef),
    .nzcv_in        (alu_flags[4:1]),
    .reg_write_raw  (reg_write_raw),
    .mem_write_raw  (mem_write_raw),
    .branch_raw     (branch_raw),
    .flag_write_raw (flag_write_raw),
    .cv_write       (cv_write),
    .rd_is_pc       (rd == 4'hF),
    .reg_write      (reg_write),
    .mem_write      (mem_write),
    .pc_src         (pc_src),
    .halted         (halted)
  );

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed instructions push expected
// strobes, a negedge monitor pops and compares them.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cond = 4'hE;
  logic [1:0] op = 2'b00;
  logic [5:0] funct = 6'b101000;
  logic [3:0] rd = 4'h0;
  logic [4:0] alu_flags = 5'b00000;
  logic       pc_src, mem_to_reg, mem_write, alu_src, reg_write, halted;
  logic [3:0] alu_control;
  logic [1:0] reg_src;

  typedef struct packed {
    logic       pc_src;
    logic       mem_to_reg;
    logic       mem_write;
    logic [3:0] alu_control;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] reg_src;
    logic       halted;
  } exp_t;

  typedef struct {
    string name;
    exp_t  exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  control_unit dut (
    .clk(clk), .rst(rst), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .alu_flags(alu_flags), .pc_src(pc_src), .mem_to_reg(mem_to_reg),
    .mem_write(mem_write), .alu_control(alu_control), .alu_src(alu_src),
    .reg_write(reg_write), .reg_src(reg_src), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic pc, input logic m2r, input logic mw,
                              input logic [3:0] alu, input logic asrc,
                              input logic rw, input logic [1:0] rs, input logic h);
    mk = '{pc, m2r, mw, alu, asrc, rw, rs, h};
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got pc=%b m2r=%b mw=%b alu=%b asrc=%b rw=%b rs=%b h=%b, want pc=%b m2r=%b mw=%b alu=%b asrc=%b rw=%b rs=%b h=%b",
               name, got.pc_src, got.mem_to_reg, got.mem_write, got.alu_control,
               got.alu_src, got.reg_write, got.reg_src, got.halted,
               exp.pc_src, exp.mem_to_reg, exp.mem_write, exp.alu_control,
               exp.alu_src, exp.reg_write, exp.reg_src, exp.halted);
    end
  endtask

  // Drive one instruction just after the edge and queue its expected strobes.
  task automatic step(input string name, input logic r, input logic [3:0] c,
                      input logic [1:0] o, input logic [5:0] f,
                      input logic [3:0] d, input logic [4:0] fl, input exp_t e);
    sb_entry_t ent;
    @(posedge clk);
    #1;
    rst = r; cond = c; op = o; funct = f; rd = d; alu_flags = fl;
    ent.name = name;
    ent.exp  = e;
    sb.push_back(ent);
  endtask

  initial begin : monitor
    sb_entry_t ent;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        ent = sb.pop_front();
        check(ent.name, {pc_src, mem_to_reg, mem_write, alu_control, alu_src,
                         reg_write, reg_src, halted}, ent.exp);
      end
    end
  end

  localparam logic [3:0] CMP_ALU =
`ifdef CONTROL_UNIT_CMP_EN
    4'b0001;
`else
    4'b0000;
`endif
  localparam logic [3:0] TST_ALU =
`ifdef CONTROL_UNIT_CMP_EN
    4'b0010;
`else
    4'b0000;
`endif
  localparam logic BEQ_AFTER_TST =
`ifdef CONTROL_UNIT_CMP_EN
    1'b1;
`else
    1'b0;
`endif

  initial begin : stimulus
    // Reset for three cycles, one START cycle, then the first instruction runs.
    for (int i = 0; i < 3; i++)
      step("rst_add", 1, 4'hE, 2'b00, 6'b101000, 4'h0, 5'b0, mk(0,0,0,4'b0000,1,0,2'b10,0));
    step("start_add", 0, 4'hE, 2'b00, 6'b101000, 4'h0, 5'b0, mk(0,0,0,4'b0000,1,0,2'b10,0));
    step("run_add",   0, 4'hE, 2'b00, 6'b101000, 4'h0, 5'b0, mk(0,0,0,4'b0000,1,1,2'b10,0));
    // Z-conditioned branch, taken then not taken.
    step("subs_z1",   0, 4'hE, 2'b00, 6'b100101, 4'h1, 5'b01000, mk(0,0,0,4'b0001,1,1,2'b10,0));
    step("beq_taken", 0, 4'h0, 2'b10, 6'b000000, 4'h0, 5'b0, mk(1,0,0,4'b0000,1,0,2'b01,0));
    step("subs_z0",   0, 4'hE, 2'b00, 6'b100101, 4'h1, 5'b00000, mk(0,0,0,4'b0001,1,1,2'b10,0));
    step("beq_not",   0, 4'h0, 2'b10, 6'b000000, 4'h0, 5'b0, mk(0,0,0,4'b0000,1,0,2'b01,0));
    // Memory ops.
    step("str",       0, 4'hE, 2'b01, 6'b011000, 4'h2, 5'b0, mk(0,0,1,4'b0000,1,0,2'b10,0));
    step("ldr",       0, 4'hE, 2'b01, 6'b011001, 4'h2, 5'b0, mk(0,1,0,4'b0000,1,1,2'b10,0));
    // PC write, always and never.
    step("add_pc_al", 0, 4'hE, 2'b00, 6'b001000, 4'hF, 5'b0, mk(1,0,0,4'b0000,0,1,2'b00,0));
    step("add_pc_nv", 0, 4'hF, 2'b00, 6'b001000, 4'hF, 5'b0, mk(0,0,0,4'b0000,0,0,2'b00,0));
    // ORRS must keep C,V set by the preceding ADDS.
    step("adds_cv",   0, 4'hE, 2'b00, 6'b101001, 4'h3, 5'b00110, mk(0,0,0,4'b0000,1,1,2'b10,0));
    step("orrs_n",    0, 4'hE, 2'b00, 6'b111001, 4'h3, 5'b10000, mk(0,0,0,4'b0011,1,1,2'b10,0));
    step("bvs_held",  0, 4'h6, 2'b10, 6'b000000, 4'h0, 5'b0, mk(1,0,0,4'b0000,1,0,2'b01,0));
    step("bmi",       0, 4'h4, 2'b10, 6'b000000, 4'h0, 5'b0, mk(1,0,0,4'b0000,1,0,2'b01,0));
    // CMP code: flags become NZCV=1001 in either build.
    step("cmp",       0, 4'hE, 2'b00, 6'b010101, 4'h0, 5'b10010, mk(0,0,0,CMP_ALU,0,0,2'b00,0));
    step("blt_fail",  0, 4'hB, 2'b10, 6'b000000, 4'h0, 5'b0, mk(0,0,0,4'b0000,1,0,2'b01,0));
    step("bge_pass",  0, 4'hA, 2'b10, 6'b000000, 4'h0, 5'b0, mk(1,0,0,4'b0000,1,0,2'b01,0));
    // TST without S bit: only the enabled build updates Z.
    step("tst",       0, 4'hE, 2'b00, 6'b010000, 4'h0, 5'b01000, mk(0,0,0,TST_ALU,0,0,2'b00,0));
    step("beq_tst",   0, 4'h0, 2'b10, 6'b000000, 4'h0, 5'b0, mk(BEQ_AFTER_TST,0,0,4'b0000,1,0,2'b01,0));
    // Undefined opcode halts the core from the next cycle.
    step("undef",     0, 4'hE, 2'b11, 6'b000000, 4'h0, 5'b0, mk(0,0,0,4'b0000,0,0,2'b00,0));
    for (int i = 0; i < 10; i++)
      step("halt_hold", 0, 4'hE, 2'b00, 6'b101001, 4'hF, 5'b11110, mk(0,0,0,4'b0000,1,0,2'b10,1));
    step("halt_rst",  1, 4'hE, 2'b00, 6'b101001, 4'hF, 5'b11110, mk(0,0,0,4'b0000,1,0,2'b10,1));
    step("rst_start", 0, 4'hE, 2'b00, 6'b101000, 4'hF, 5'b0, mk(0,0,0,4'b0000,1,0,2'b10,0));
    step("rst_run",   0, 4'hE, 2'b00, 6'b101000, 4'hF, 5'b0, mk(1,0,0,4'b0000,1,1,2'b10,0));
    step("bvc_clear", 0, 4'h7, 2'b10, 6'b000000, 4'h0, 5'b0, mk(1,0,0,4'b0000,1,0,2'b01,0));
    // Reset beats a simultaneous undefined opcode.
    step("rst_undef", 1, 4'hE, 2'b11, 6'b000000, 4'h0, 5'b0, mk(0,0,0,4'b0000,0,0,2'b00,0));
    step("start2",    0, 4'hE, 2'b00, 6'b101000, 4'h0, 5'b0, mk(0,0,0,4'b0000,1,0,2'b10,0));
    step("run2",      0, 4'hE, 2'b00, 6'b101000, 4'h0, 5'b0, mk(0,0,0,4'b0000,1,1,2'b10,0));

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
